// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; single-cycle logic ops and
// add/sub/slt, plus an iterative shift-add multiply that takes WIDTH edges.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [2:0]       aluCtrl,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [0:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    // Shared adder: bit2 of aluCtrl inverts B and supplies the carry-in.
    logic [WIDTH-1:0] bsel;
    logic [WIDTH:0]   sum;
    logic             ovf_sum;

    assign bsel    = aluCtrl[2] ? ~inb : inb;
    assign sum     = {1'b0, ina} + {1'b0, bsel} + {{WIDTH{1'b0}}, aluCtrl[2]};
    assign ovf_sum = (ina[WIDTH-1] == bsel[WIDTH-1]) & (sum[WIDTH-1] != ina[WIDTH-1]);

    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (aluCtrl)
            OP_AND: res = ina & inb;
            OP_OR:  res = ina | inb;
            OP_XOR: res = ina ^ inb;
            OP_NOR: res = ~(ina | inb);
            OP_ADD, OP_SUB: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = ovf_sum;
            end
            OP_SLT: begin
                res       = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_sum};
                res_carry = sum[WIDTH];
                res_ovf   = ovf_sum;
            end
            default: res = '0;
        endcase
    end

    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt_next;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign cnt_next = cnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            out    <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (aluCtrl == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, ina};
                            mplier <= inb;
                            acc    <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= ST_MUL;
                        end else begin
                            out   <= res;
                            zero  <= (res == '0);
                            carry <= res_carry;
                            ovf   <= res_ovf;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt_next;
                    if (cnt_next == CNT_W'(WIDTH)) begin
                        out   <= acc_next[WIDTH-1:0];
                        zero  <= (acc_next[WIDTH-1:0] == '0);
                        carry <= |acc_next[2*WIDTH-1:WIDTH];
                        ovf   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): single-cycle ops, flags, multiply
// latency, ignored start while busy, async reset mid-multiply, back-to-back ops.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] ina = '0;
    logic [W-1:0] inb = '0;
    logic [2:0]   aluCtrl = 3'b000;
    logic [W-1:0] out;
    logic         zero, carry, ovf, busy, done;

    int compared = 0;
    int mismatched = 0;
    int done_cnt;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ina(ina), .inb(inb),
        .aluCtrl(aluCtrl), .out(out), .zero(zero), .carry(carry), .ovf(ovf),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; aluCtrl = op; ina = a; inb = b;
    endtask

    task automatic check_flags(input string tag, input logic [W-1:0] e_out,
                               input logic e_zero, input logic e_carry, input logic e_ovf);
        check({tag, ".out"},   16'(out),   16'(e_out));
        check({tag, ".zero"},  16'(zero),  16'(e_zero));
        check({tag, ".carry"}, 16'(carry), 16'(e_carry));
        check({tag, ".ovf"},   16'(ovf),   16'(e_ovf));
    endtask

    initial begin
        // Reset state
        #12;
        check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.busy", 16'(busy), 16'd0);
        check("reset.done", 16'(done), 16'd0);
        rst_n = 1'b1;
        step();

        // ADD with signed overflow
        issue(3'b010, 8'h7F, 8'h01);
        step();
        check_flags("add", 8'h80, 1'b0, 1'b0, 1'b1);
        check("add.done", 16'(done), 16'd1);
        check("add.busy", 16'(busy), 16'd0);
        start = 1'b0;
        step();
        check("add.done_pulse", 16'(done), 16'd0);

        // SUB equal operands: no borrow, zero result
        issue(3'b110, 8'h05, 8'h05);
        step();
        check_flags("sub", 8'h00, 1'b1, 1'b1, 1'b0);
        check("sub.done", 16'(done), 16'd1);

        // Signed SLT across overflow
        issue(3'b111, 8'h80, 8'h01);
        step();
        check("slt_neg.out", 16'(out), 16'h01);
        check("slt_neg.ovf", 16'(ovf), 16'd1);
        issue(3'b111, 8'h7F, 8'h80);
        step();
        check("slt_pos.out", 16'(out), 16'h00);
        check("slt_pos.zero", 16'(zero), 16'd1);
        start = 1'b0;
        step();

        // MUL 0x0D x 0x0B with an ignored ADD start and operand changes mid-flight
        issue(3'b011, 8'h0D, 8'h0B);
        step();
        start = 1'b0;
        check("mul1.busy_start", 16'(busy), 16'd1);
        check("mul1.hold_out", 16'(out), 16'h00);
        check("mul1.hold_done", 16'(done), 16'd0);
        done_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 2) issue(3'b010, 8'h33, 8'h44);
            else if (i == 3) begin start = 1'b0; ina = 8'hFF; inb = 8'hFF; end
            step();
            if (done) done_cnt++;
            check($sformatf("mul1.busy_%0d", i), 16'(busy), 16'd1);
        end
        start = 1'b0;
        check("mul1.no_early_done", 16'(done_cnt), 16'd0);
        step();
        check("mul1.done", 16'(done), 16'd1);
        check("mul1.busy_end", 16'(busy), 16'd0);
        check_flags("mul1", 8'h8F, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("mul1.single_done", 16'(done_cnt), 16'd0);
        check("mul1.add_not_run", 16'(out), 16'h8F);

        // MUL 0x10 x 0x10: low byte zero, high part sets carry
        issue(3'b011, 8'h10, 8'h10);
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("mul2.not_yet", 16'(done), 16'd0);
        step();
        check("mul2.done", 16'(done), 16'd1);
        check_flags("mul2", 8'h00, 1'b1, 1'b1, 1'b0);
        step();

        // Async reset during cycle 4 of a multiply
        issue(3'b011, 8'h0D, 8'h0B);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("rst.busy_before", 16'(busy), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_async.busy", 16'(busy), 16'd0);
        check("rst_async.done", 16'(done), 16'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) done_cnt++;
        end
        check("rst.no_done_after", 16'(done_cnt), 16'd0);
        issue(3'b000, 8'hF0, 8'h3C);
        step();
        check("rst.and.out", 16'(out), 16'h30);
        check("rst.and.done", 16'(done), 16'd1);
        start = 1'b0;
        step();

        // Back-to-back single-cycle ops with start held high
        issue(3'b000, 8'hAA, 8'h0F);
        step();
        check("b2b.and.out", 16'(out), 16'h0A);
        check("b2b.and.done", 16'(done), 16'd1);
        aluCtrl = 3'b001;
        step();
        check("b2b.or.out", 16'(out), 16'hAF);
        check("b2b.or.done", 16'(done), 16'd1);
        aluCtrl = 3'b100;
        step();
        check("b2b.xor.out", 16'(out), 16'hA5);
        check("b2b.xor.done", 16'(done), 16'd1);
        aluCtrl = 3'b101;
        step();
        check("b2b.nor.out", 16'(out), 16'h50);
        check("b2b.nor.done", 16'(done), 16'd1);
        check("b2b.nor.carry", 16'(carry), 16'd0);
        start = 1'b0;
        step();
        check("b2b.done_drop", 16'(done), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Adds registered result/flags, start/busy/done handshake, carry and signed-overflow flags, correct signed SLT, XOR/NOR, and an iterative shift-add multiply.
- Sits between the register file read ports and the writeback mux of the datapath.
- The controller stalls on busy.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request, sampled only when busy=0
- ina  input  WIDTH  operand A
- inb  input  WIDTH  operand B
- aluCtrl  input  3  operation select: bit2 = invert B / carry-in for subtract
- out  output  WIDTH  registered result
- zero  output  1  registered: out == 0
- carry  output  1  registered carry/unsigned-overflow flag
- ovf  output  1  registered signed-overflow flag
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse: out and flags updated this cycle

Behaviour:
- Reset is asynchronous on rst_n=0. All outputs go to 0, the FSM goes to IDLE, and internal accumulator, multiplicand, multiplier and counter clear.
- aluCtrl encoding:
  - 000 AND; 001 OR; 010 ADD; 110 SUB (A + ~B + 1).
  - 111 SLT: signed, result = {0..0, sum[W-1] ^ ovf_sub}.
  - 100 XOR; 101 NOR; 011 MUL (unsigned, low WIDTH bits).
- FSM states are IDLE and MUL.
- IDLE, start=1, non-MUL op: at that edge, out/zero/carry/ovf load the combinational result and done=1 for exactly one cycle. Latency is 1 edge. busy stays 0.
- IDLE, start=1, aluCtrl=011:
  - Capture ina as multiplicand and inb as multiplier; clear accumulator and counter.
  - busy=1, go to MUL. Outputs hold their previous values.
- MUL, each edge:
  - If multiplier[0], acc += multiplicand (2*WIDTH-bit accumulator).
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - On the edge where counter reaches WIDTH: out = acc[W-1:0] (including this edge's add), carry = |acc[2W-1:W], ovf=0, zero updated, done=1, busy=0, go to IDLE.
  - done therefore rises WIDTH edges after the start edge.
- Inputs ina/inb/aluCtrl are ignored while busy=1; operands are captured at start.
- start while busy=1 is ignored: it is not queued and produces no extra done.
- start may be held high in IDLE. Each edge issues a new op back to back, so done stays high on consecutive cycles for single-cycle ops.
- Flags:
  - ADD: carry = carry-out. SUB/SLT: carry = carry-out (1 = no borrow).
  - ovf = (A[W-1]==B'[W-1]) & (sum[W-1]!=A[W-1]) for ADD/SUB/SLT, where B' is the inverted B for SUB/SLT.
  - AND/OR/XOR/NOR: carry=0, ovf=0.
- zero always reflects the registered out.
- Reset asserted mid-multiply aborts immediately. No done pulse is produced after reset release; the FSM returns to IDLE.
- Unused/reserved encodings: none, all 8 encodings are defined.

Test Plan (WIDTH=8):
1. Reset, then ADD ina=0x7F, inb=0x01 with start for one cycle -> next edge: out=0x80, zero=0, carry=0, ovf=1, done=1 for one cycle, busy=0.
2. SUB ina=0x05, inb=0x05 -> out=0x00, zero=1, carry=1, ovf=0; then SLT ina=0x80 (-128), inb=0x01 -> out=0x01. Also SLT ina=0x7F, inb=0x80 -> out=0x00, confirming signed compare is correct across overflow.
3. MUL ina=0x0D, inb=0x0B -> busy=1 for 8 cycles, done exactly 8 edges after the start edge, out=0x8F, carry=0. Then MUL 0x10 x 0x10 -> out=0x00, zero=1, carry=1.
4. During the 0x0D x 0x0B multiply, pulse start with ADD and change ina/inb mid-operation -> result still 0x8F, only one done pulse, the ADD is not executed.
5. Assert rst_n=0 at cycle 4 of a MUL -> out/flags/busy/done go to 0 asynchronously. After release: no done pulse, and a fresh AND 0xF0 & 0x3C gives out=0x30.
6. Hold start=1 over 4 cycles issuing AND, OR, XOR, NOR on 0xAA/0x0F -> done high for 4 consecutive cycles, outs 0x0A, 0xAF, 0xA5, 0x50.
